imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the Core101 fetch path. It holds the program image, accepts word fetch requests from the core's instruction memory interface, and returns the addressed instruction after a fixed, parameterised number of wait states. A side-band load port lets the bench or boot logic write the program image. Only one fetch is outstanding at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 1: extra cycles between request acceptance and response; legal range 0–15.

Ports:
- `clock_in`  in  1  Single clock; all logic is rising-edge.
- `reset_in`  in  1  Reset; asynchronous assert, active-low.
- `ins_mem_req_in`  in  1  Fetch request strobe.
- `ins_mem_addr_in`  in  32  Byte address of the fetch.
- `ins_mem_data_out`  out  32  Fetched instruction word.
- `ins_mem_valid_out`  out  1  One-cycle pulse: `ins_mem_data_out` holds a new response.
- `ins_mem_busy_out`  out  1  High while a fetch is in wait states; requests are ignored.
- `ins_mem_err_out`  out  1  Response error flag; exists only under the macro below.
- `prog_we_in`  in  1  Program-load write enable.
- `prog_addr_in`  in  ADDR_WIDTH  Program-load word address.
- `prog_data_in`  in  32  Program-load data.

## Operation
- FSM states:
  - IDLE: no fetch outstanding.
  - WAIT: counting wait states.
  - RESP: response presented this cycle.
- Acceptance:
  - A request is accepted on a rising edge where `ins_mem_req_in`=1 and the state is IDLE or RESP.
  - On acceptance, word index `ins_mem_addr_in[ADDR_WIDTH+1:2]` is latched and the wait counter is loaded with WAIT_STATES.
- Transitions:
  - On accept: go to WAIT if WAIT_STATES>0, otherwise go to RESP.
  - WAIT: decrement the counter; when it is 1, the next state is RESP.
  - RESP: on a new accept, follow the accept rule (back-to-back fetches); otherwise go to IDLE.
- Array read:
  - The array is read on the edge that enters RESP.
  - `ins_mem_data_out` is registered at that edge and held until the next response.
- Busy: `ins_mem_busy_out` = (state==WAIT). When `ins_mem_req_in` is high during WAIT, the request is dropped, not queued.
- Address handling:
  - Address bits [1:0] are ignored.
  - Bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo depth.
- Program load:
  - `prog_we_in`=1 writes `prog_data_in` to `prog_addr_in` at the rising edge.
  - Writes are accepted in any FSM state.
  - A write that lands on the same edge as the array read of the same word returns the old word (read-before-write).
- Reset mid-operation:
  - State → IDLE; the outstanding fetch is discarded and no response is issued.
  - Memory contents are not cleared.
  - Writes and requests arriving while `reset_in`=0 are ignored.

## Timing
- Reset values: `ins_mem_data_out`=32'h0000_0000, `ins_mem_valid_out`=0, `ins_mem_busy_out`=0, `ins_mem_err_out`=0, state IDLE, counter 0.
- Latency: request accepted at edge N → `ins_mem_valid_out`=1 during cycle N+1+WAIT_STATES.
- Throughput:
  - One response per WAIT_STATES+1 cycles when the request is held high continuously.
  - With WAIT_STATES=0, one response per cycle.
- `ins_mem_valid_out` is high for exactly one cycle per accepted request.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CORE101_IMEM_ERR_EN` defined:
  - `ins_mem_err_out` exists. It is asserted with `ins_mem_valid_out` (same cycle, one-cycle pulse) when the accepted address had bits[1:0]≠0 or any bit above ADDR_WIDTH+1 set.
  - On error, `ins_mem_data_out` = 32'h0000_0013 (NOP) instead of the array word.
- `CORE101_IMEM_ERR_EN` undefined: the port is absent, and addresses are silently truncated and wrapped as described in Operation.

## Test plan
- Load word 0 = 32'hDEAD_BEEF with WAIT_STATES=1; request addr 0x0 at edge N → valid=1 and data=DEADBEEF in cycle N+2; busy=1 in cycle N+1 only.
- WAIT_STATES=0; hold req high with addresses 0x0, 0x4, 0x8 (words preloaded 1, 2, 3) → valid high three consecutive cycles with data 1, 2, 3.
- WAIT_STATES=3; send req at addr 0x4, then req at 0x8 one cycle later → only one response (word 1) after 4 cycles; the second request is dropped.
- Program write to word 5 = 32'h1234_5678 on the same edge a fetch of 0x14 enters RESP (old value 32'hAAAA_AAAA) → returns AAAAAAAA; next fetch returns 12345678.
- Assert reset_in=0 during WAIT → no valid pulse; data_out=0; memory word 0 still DEADBEEF after release.
- With `CORE101_IMEM_ERR_EN`, ADDR_WIDTH=10: fetch 0x0000_1002 → err=1, data=00000013; without the macro, the same fetch returns word 0.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: program image, single outstanding word fetch, fixed wait states.
// Optional response error flag and NOP substitution enabled by defining CORE101_IMEM_ERR_EN.
module imem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  ins_mem_req_in,
    input  logic [31:0]           ins_mem_addr_in,
    output logic [31:0]           ins_mem_data_out,
    output logic                  ins_mem_valid_out,
    output logic                  ins_mem_busy_out,
`ifdef CORE101_IMEM_ERR_EN
    output logic                  ins_mem_err_out,
`endif
    input  logic                  prog_we_in,
    input  logic [ADDR_WIDTH-1:0] prog_addr_in,
    input  logic [31:0]           prog_data_in
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]           mem_q [DEPTH];
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  accept;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] in_word;
    logic [ADDR_WIDTH-1:0] rd_word;

    assign in_word = ins_mem_addr_in[ADDR_WIDTH+1:2];

`ifdef CORE101_IMEM_ERR_EN
    logic in_err;
    logic err_now;
    logic err_pend_q, err_pend_d;
    logic err_q, err_d;

    assign in_err = (|ins_mem_addr_in[1:0]) | (|ins_mem_addr_in[31:ADDR_WIDTH+2]);
`else
    // Byte offset and high address bits are deliberately dropped (wrap modulo depth).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ins_mem_addr_in[1:0], ins_mem_addr_in[31:ADDR_WIDTH+2]};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        enter_resp = 1'b0;
        rd_word    = addr_q;
        accept     = ins_mem_req_in && (state_q != S_WAIT);

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // With zero wait states the array is read on the accepting edge, straight from the input.
        if (accept) begin
            addr_d = in_word;
            cnt_d  = WS;
            if (WS == 4'd0) begin
                state_d    = S_RESP;
                enter_resp = 1'b1;
                rd_word    = in_word;
            end else begin
                state_d = S_WAIT;
            end
        end

`ifdef CORE101_IMEM_ERR_EN
        err_pend_d = accept ? in_err : err_pend_q;
        err_now    = (accept && (WS == 4'd0)) ? in_err : err_pend_q;
        err_d      = enter_resp && err_now;
        if (enter_resp) data_d = err_now ? NOP : mem_q[rd_word];
`else
        if (enter_resp) data_d = mem_q[rd_word];
`endif
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= 32'h0000_0000;
`ifdef CORE101_IMEM_ERR_EN
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef CORE101_IMEM_ERR_EN
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
`endif
        end
    end

    // NOTE: the program array has no reset so it survives reset_in and maps onto RAM;
    // writes are still blocked while reset is asserted.
    always_ff @(posedge clock_in) begin
        if (reset_in && prog_we_in) mem_q[prog_addr_in] <= prog_data_in;
    end

    assign ins_mem_data_out  = data_q;
    assign ins_mem_valid_out = (state_q == S_RESP);
    assign ins_mem_busy_out  = (state_q == S_WAIT);
`ifdef CORE101_IMEM_ERR_EN
    assign ins_mem_err_out   = err_q;
`endif

endmodule
